// File: rtl/main_ctrl_if.sv
// Control bundle between the multicycle main controller and the datapath.
// The master side is the FSM: it reads opcode and zero flag and drives all controls.
interface main_ctrl_if;
    logic [5:0] op;
    logic       zero;
    logic [2:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, zero,
        output aluop, alusrca, alusrcb, zeroext, pcsrc, pcen, irwrite,
               memwrite, regwrite, iord, regdst, memtoreg, illegal, state
    );

    modport slave (
        output op, zero,
        input  aluop, alusrca, alusrcb, zeroext, pcsrc, pcen, irwrite,
               memwrite, regwrite, iord, regdst, memtoreg, illegal, state
    );
endinterface

// File: rtl/main_ctrl_fsm.sv
// Multicycle Moore main controller: state register plus registered control word,
// with write enables gated by reset and the branch PC enable qualified by zero.
module main_ctrl_fsm (
    input  logic       clk,
    input  logic       rst,
    main_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB = 4'd7,
        BRANCH = 4'd8,  IEXEC  = 4'd9,  IWB    = 4'd10, JUMP  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef struct packed {
        logic [2:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       branch;
    } ctrl_t;

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl_q;

    function automatic state_t next_state(input state_t s, input logic [5:0] op);
        case (s)
            FETCH:  return DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW:              return MEMADR;
                    OP_RTYPE:                  return EXEC;
                    OP_BEQ:                    return BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:  return IEXEC;
                    OP_J:                      return JUMP;
                    default:                   return FETCH;
                endcase
            end
            MEMADR: return (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  return MEMWB;
            EXEC:   return ALUWB;
            IEXEC:  return IWB;
            default: return FETCH;
        endcase
    endfunction

    // op is only meaningful for IEXEC, whose controls are loaded while op is stable in DECODE.
    function automatic ctrl_t decode(input state_t s, input logic [5:0] op);
        // NOTE: start from an all-zero word so every path assigns every field; no latches, no stale bits.
        ctrl_t c = '0;
        case (s)
            FETCH:  begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcen = 1'b1; end
            DECODE: c.alusrcb = 2'b11;
            MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            MEMRD:  c.iord = 1'b1;
            MEMWB:  begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            MEMWR:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
            EXEC:   begin c.alusrca = 1'b1; c.aluop = 3'b010; end
            ALUWB:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            BRANCH: begin c.alusrca = 1'b1; c.aluop = 3'b001; c.pcsrc = 2'b01; c.branch = 1'b1; end
            IEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                case (op)
                    OP_ANDI: begin c.aluop = 3'b100; c.zeroext = 1'b1; end
                    OP_ORI:  begin c.aluop = 3'b011; c.zeroext = 1'b1; end
                    default: begin c.aluop = 3'b000; c.zeroext = 1'b0; end
                endcase
            end
            IWB:    c.regwrite = 1'b1;
            JUMP:   begin c.pcsrc = 2'b10; c.pcen = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic op_supported(input logic [5:0] op);
        return op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J};
    endfunction

    assign state_nxt = next_state(state, bus.op);

    // The control word is registered alongside the state so outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH;
            ctrl_q <= decode(FETCH, 6'd0);
        end else begin
            // NOTE: non-blocking updates keep state and ctrl_q sampling the same pre-edge values.
            state  <= state_nxt;
            ctrl_q <= decode(state_nxt, bus.op);
        end
    end

    assign bus.state    = state;
    assign bus.aluop    = ctrl_q.aluop;
    assign bus.alusrca  = ctrl_q.alusrca;
    assign bus.alusrcb  = ctrl_q.alusrcb;
    assign bus.zeroext  = ctrl_q.zeroext;
    assign bus.pcsrc    = ctrl_q.pcsrc;
    assign bus.iord     = ctrl_q.iord;
    assign bus.regdst   = ctrl_q.regdst;
    assign bus.memtoreg = ctrl_q.memtoreg;

    // Write enables drop the instant reset rises, without waiting for a clock.
    assign bus.pcen     = ~rst & (ctrl_q.pcen | (ctrl_q.branch & bus.zero));
    assign bus.irwrite  = ~rst & ctrl_q.irwrite;
    assign bus.memwrite = ~rst & ctrl_q.memwrite;
    assign bus.regwrite = ~rst & ctrl_q.regwrite;

    // op is loaded into the IR on the FETCH edge, so legality can only be judged live in DECODE.
    assign bus.illegal  = ~rst & (state == DECODE) & ~op_supported(bus.op);
endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Self-checking bench for main_ctrl_fsm: directed instructions, reset abort, then
// random instruction streams compared against a per-instruction reference model.
module tb_main_ctrl_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    main_ctrl_if bus ();

    main_ctrl_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: instruction class -> the state trail from FETCH up to the next FETCH.
    function automatic void expected_trail(input logic [5:0] op, output int trail[$]);
        case (op)
            6'b100011:                       trail = '{0, 1, 2, 3, 4};
            6'b101011:                       trail = '{0, 1, 2, 5};
            6'b000000:                       trail = '{0, 1, 6, 7};
            6'b000100:                       trail = '{0, 1, 8};
            6'b001000, 6'b001100, 6'b001101: trail = '{0, 1, 9, 10};
            6'b000010:                       trail = '{0, 1, 11};
            default:                         trail = '{0, 1};
        endcase
    endfunction

    function automatic logic legal(input logic [5:0] op);
        int trail[$];
        expected_trail(op, trail);
        return (trail.size() > 2);
    endfunction

    // Expected output word {aluop, alusrca, alusrcb, zeroext, pcsrc, iord, regdst, memtoreg, illegal}.
    function automatic logic [13:0] expected_ctrl(input int s, input logic [5:0] op, input logic in_rst);
        logic [2:0] aluop = 3'b000;
        logic a = 1'b0, ze = 1'b0, iord = 1'b0, rd = 1'b0, m2r = 1'b0, ill = 1'b0;
        logic [1:0] b = 2'b00, pcs = 2'b00;
        case (s)
            0: b = 2'b01;
            1: begin b = 2'b11; ill = ~legal(op) & ~in_rst; end
            2: begin a = 1'b1; b = 2'b10; end
            3: iord = 1'b1;
            4: m2r = 1'b1;
            5: iord = 1'b1;
            6: begin a = 1'b1; aluop = 3'b010; end
            7: rd = 1'b1;
            8: begin a = 1'b1; aluop = 3'b001; pcs = 2'b01; end
            9: begin
                a = 1'b1; b = 2'b10;
                if (op == 6'b001100) begin aluop = 3'b100; ze = 1'b1; end
                else if (op == 6'b001101) begin aluop = 3'b011; ze = 1'b1; end
            end
            11: pcs = 2'b10;
            default: ;
        endcase
        return {aluop, a, b, ze, pcs, iord, rd, m2r, ill};
    endfunction

    // Expected write enables {pcen, irwrite, memwrite, regwrite}.
    function automatic logic [3:0] expected_we(input int s, input logic z, input logic in_rst);
        logic [3:0] we;
        case (s)
            0:          we = 4'b1100;
            4, 7, 10:   we = 4'b0001;
            5:          we = 4'b0010;
            8:          we = {z, 3'b000};
            11:         we = 4'b1000;
            default:    we = 4'b0000;
        endcase
        return in_rst ? 4'b0000 : we;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int s, input logic [5:0] op);
        logic [13:0] obs_ctrl;
        logic [3:0]  obs_we;
        obs_ctrl = {bus.aluop, bus.alusrca, bus.alusrcb, bus.zeroext, bus.pcsrc,
                    bus.iord, bus.regdst, bus.memtoreg, bus.illegal};
        obs_we   = {bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite};
        check({tag, ".state"}, 32'(bus.state), 32'(s));
        check({tag, ".ctrl"},  32'(obs_ctrl), 32'(expected_ctrl(s, op, rst)));
        check({tag, ".we"},    32'(obs_we),   32'(expected_we(s, bus.zero, rst)));
    endtask

    // Entered and left at 1 time unit after a falling edge; runs at most max_steps cycles.
    task automatic run_instr(input string tag, input logic [5:0] op, input int zero_mode, input int max_steps);
        int trail[$];
        expected_trail(op, trail);
        bus.op = op;
        for (int k = 0; k < trail.size() && k < max_steps; k++) begin
            bus.zero = (zero_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(zero_mode);
            #1;
            check_outputs($sformatf("%s[%0d]", tag, k), trail[k], op);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] legal_ops[8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                     6'b001000, 6'b001100, 6'b001101, 6'b000010};
        logic [5:0] rop;

        bus.op   = 6'b000000;
        bus.zero = 1'b0;

        // Held in reset across clock edges: FETCH values with every write enable low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_outputs("reset", 0, bus.op);
        rst = 1'b0;

        run_instr("lw",   6'b100011, 0, 99);
        run_instr("rtype", 6'b000000, 0, 99);
        run_instr("beq_z1", 6'b000100, 1, 99);
        run_instr("beq_z0", 6'b000100, 0, 99);
        run_instr("ori",  6'b001101, 0, 99);
        run_instr("andi", 6'b001100, 0, 99);
        run_instr("addi", 6'b001000, 0, 99);
        run_instr("j",    6'b000010, 0, 99);
        run_instr("ill",  6'b111111, 0, 99);
        run_instr("sw",   6'b101011, 0, 99);

        // Abort a store in MEMWR with a reset pulse placed between clock edges.
        run_instr("sw_abort", 6'b101011, 0, 3);
        #1;
        check_outputs("memwr_before_rst", 5, bus.op);
        #1;
        rst = 1'b1;
        #1;
        check_outputs("rst_async", 0, bus.op);
        @(posedge clk);
        #1;
        check_outputs("rst_held_edge", 0, bus.op);
        @(negedge clk);
        #1;
        rst = 1'b0;
        run_instr("after_rst_lw", 6'b100011, -1, 99);

        // Random instruction stream including unsupported opcodes.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do rop = 6'($urandom); while (legal(rop));
            end else begin
                rop = legal_ops[$urandom_range(0, 7)];
            end
            run_instr($sformatf("rnd%0d_op%02h", n, rop), rop, -1, 99);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/main_ctrl_fsm.md
MAIN_CTRL_FSM -- requirements
Module: main_ctrl_fsm

Interface
REQ-001 clk  input  1  rising-edge system clock.
REQ-002 rst  input  1  reset; asynchronous, active-high.
REQ-003 op  input  6  opcode from instruction register; stable from DECODE until return to FETCH.
REQ-004 zero  input  1  ALU zero flag.
REQ-005 aluop  output  3  ALU operation class to aluctrl: 000 add, 001 sub, 010 use funct, 011 or, 100 and.
REQ-006 alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-007 alusrcb  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = immediate, 11 = immediate<<2.
REQ-008 zeroext  output  1  1 = zero-extend immediate, 0 = sign-extend.
REQ-009 pcsrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-010 pcen  output  1  PC write enable.
REQ-011 irwrite, memwrite, regwrite  outputs  1 each  instruction-register, memory and register-file write enables.
REQ-012 iord, regdst, memtoreg  outputs  1 each  memory address = ALUOut; write register = rd; write data = memory.
REQ-013 illegal  output  1  unsupported opcode seen in DECODE.
REQ-014 state  output  4  current state encoding, for debug.

Function
REQ-015 Multicycle Moore control FSM; every output is a function of state (and op in IEXEC); pcen additionally depends on zero.
REQ-016 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11; codes 12-15 go to FETCH next cycle with all enables 0.
REQ-017 Unlisted outputs in any state are 0.
REQ-018 FETCH: iord=0, alusrca=0, alusrcb=01, aluop=000, pcsrc=00, irwrite=1, pcen=1; next state DECODE.
REQ-019 DECODE: alusrca=0, alusrcb=11, aluop=000; next state by op:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 (R-type) -> EXEC
- 000100 (beq) -> BRANCH
- 001000 (addi), 001100 (andi), 001101 (ori) -> IEXEC
- 000010 (j) -> JUMP
- any other op -> FETCH, with illegal=1 for that cycle only.
REQ-020 MEMADR: alusrca=1, alusrcb=10, aluop=000; lw -> MEMRD, sw -> MEMWR.
REQ-021 MEMRD: iord=1 -> MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
REQ-022 MEMWR: iord=1, memwrite=1 -> FETCH.
REQ-023 EXEC: alusrca=1, alusrcb=00, aluop=010 -> ALUWB. ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
REQ-024 BRANCH: alusrca=1, alusrcb=00, aluop=001, pcsrc=01, pcen=zero (combinational, same cycle) -> FETCH.
REQ-025 IEXEC: alusrca=1, alusrcb=10; aluop=000 with zeroext=0 for addi; aluop=100 with zeroext=1 for andi; aluop=011 with zeroext=1 for ori; next state IWB.
REQ-026 IWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
REQ-027 JUMP: pcsrc=10, pcen=1 -> FETCH.
REQ-028 Instruction latency in cycles, FETCH to the following FETCH: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq 3, j 3, illegal 2.

Reset
REQ-029 rst=1 forces state=FETCH immediately, independent of clk.
REQ-030 While rst=1, pcen, irwrite, memwrite and regwrite are forced 0; all other outputs show FETCH values.
REQ-031 Reset asserted mid-instruction aborts it with no further write enables; the first FETCH cycle is the first rising clk edge after rst falls.

Verification
REQ-032 Reset, then lw (op=100011) -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; irwrite=1 only in state 0.
REQ-033 R-type (op=000000) -> aluop=010 in EXEC; regwrite=1 and regdst=1 in ALUWB; 4 cycles total.
REQ-034 beq with zero=1 -> pcen=1 and pcsrc=01 in BRANCH; repeat with zero=0 -> pcen=0; both return to FETCH after 3 cycles.
REQ-035 ori (001101) -> aluop=011 and zeroext=1 in IEXEC; andi (001100) -> aluop=100; addi (001000) -> aluop=000 and zeroext=0.
REQ-036 op=111111 -> illegal=1 for one cycle in DECODE, then FETCH, with no write enable asserted in that cycle.
REQ-037 rst pulse between clk edges while in MEMWR -> state=0 asynchronously, memwrite drops to 0 at once, and no write enable asserts while rst is high.
